// File: rtl/rr_port_arbiter.sv
// rtl/rr_port_arbiter.sv - round-robin arbiter with registered one-hot grant and hold limit
module rr_port_arbiter #(
    parameter int INPUTS   = 4,
    parameter int MAX_HOLD = 16,
    localparam int ID_W    = $clog2(INPUTS),
    localparam int CNT_W   = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [INPUTS-1:0] i_req,
    input  logic              i_done,
    output logic [INPUTS-1:0] o_gnt,
    output logic              o_gnt_valid,
    output logic [ID_W-1:0]   o_gnt_id,
    output logic              o_preempt
);

    typedef enum logic {S_IDLE, S_GRANT} state_t;

    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(MAX_HOLD);

    state_t              state_q, state_d;
    logic [INPUTS-1:0]   gnt_q, gnt_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic                pre_q, pre_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    hold_q, hold_d;

    logic                owner_req;
    logic                others;
    logic                forced;
    logic                rel;
    logic [ID_W-1:0]     nxt_ptr;
    logic [ID_W-1:0]     arb_ptr;
    logic [ID_W:0]       pick;

    // Returns {found, index}; scanning offsets downward lets the smallest offset from ptr win.
    function automatic logic [ID_W:0] rr_pick(input logic [INPUTS-1:0] req,
                                              input logic [ID_W-1:0]   ptr);
        logic [ID_W:0]   res;
        logic [ID_W-1:0] sel;
        res = '0;
        for (int i = INPUTS - 1; i >= 0; i--) begin
            sel = ID_W'((int'(ptr) + i) % INPUTS);
            if (req[sel]) res = {1'b1, sel};
        end
        return res;
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            gnt_q   <= '0;
            id_q    <= '0;
            pre_q   <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            id_q    <= id_d;
            pre_q   <= pre_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        id_d      = id_q;
        pre_d     = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        owner_req = i_req[id_q];
        others    = |(i_req & ~gnt_q);
        forced    = (MAX_HOLD != 0) && (hold_q == HOLD_MAX) && others;
        rel       = i_done | ~owner_req | forced;
        nxt_ptr   = (id_q == ID_W'(INPUTS - 1)) ? '0 : id_q + 1'b1;
        // A releasing owner re-arbitrates on the same edge from the rotated pointer.
        arb_ptr   = (state_q == S_GRANT) ? nxt_ptr : ptr_q;
        pick      = rr_pick(i_req, arb_ptr);

        case (state_q)
            S_IDLE: begin
                if (pick[ID_W]) begin
                    state_d = S_GRANT;
                    gnt_d   = {{(INPUTS-1){1'b0}}, 1'b1} << pick[ID_W-1:0];
                    id_d    = pick[ID_W-1:0];
                    hold_d  = CNT_W'(1);
                end
            end
            S_GRANT: begin
                if (rel) begin
                    ptr_d = nxt_ptr;
                    if (pick[ID_W]) begin
                        gnt_d  = {{(INPUTS-1){1'b0}}, 1'b1} << pick[ID_W-1:0];
                        id_d   = pick[ID_W-1:0];
                        hold_d = CNT_W'(1);
                        pre_d  = forced & ~i_done & owner_req;
                    end else begin
                        state_d = S_IDLE;
                        gnt_d   = '0;
                    end
                end else if (hold_q != HOLD_MAX) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    assign o_gnt       = gnt_q;
    assign o_gnt_valid = (state_q == S_GRANT);
    assign o_gnt_id    = id_q;
    assign o_preempt   = pre_q;

endmodule

// File: tb/tb_rr_port_arbiter.sv
// tb/tb_rr_port_arbiter.sv - self-checking bench for rr_port_arbiter
module tb_rr_port_arbiter;

    localparam int N     = 4;
    localparam int MH    = 4;
    localparam int BOUND = (N - 1) * MH + N;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req = '0;
    logic         done = 1'b0;
    logic [N-1:0] gnt;
    logic         valid;
    logic [1:0]   gid;
    logic         pre;

    int checks = 0;
    int errors = 0;

    rr_port_arbiter #(.INPUTS(N), .MAX_HOLD(MH)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_done(done),
        .o_gnt(gnt), .o_gnt_valid(valid), .o_gnt_id(gid), .o_preempt(pre)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] req;
        logic         done;
        logic [N-1:0] gnt;
        int           id;
        logic         pre;
    } vec_t;

    vec_t tbl[$];

    // Reference model: owner as an integer (-1 = idle), pointer and hold count as plain ints.
    int m_owner, m_last, m_ptr, m_hold;
    bit m_pre;
    int wt[N];
    int maxw;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic add(input logic [N-1:0] r, input logic d, input logic [N-1:0] g,
                       input int id, input logic p);
        vec_t v;
        v.req = r; v.done = d; v.gnt = g; v.id = id; v.pre = p;
        tbl.push_back(v);
    endtask

    function automatic int pick(input logic [N-1:0] r, input int ptr);
        for (int i = 0; i < N; i++)
            if (r[(ptr + i) % N]) return (ptr + i) % N;
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1; m_last = 0; m_ptr = 0; m_hold = 0; m_pre = 0;
        for (int i = 0; i < N; i++) wt[i] = 0;
    endtask

    task automatic model_update(input logic [N-1:0] r, input logic d);
        int  k, w;
        bit  frc;
        m_pre = 0;
        if (m_owner < 0) begin
            w = pick(r, m_ptr);
            if (w >= 0) begin m_owner = w; m_last = w; m_hold = 1; end
        end else begin
            k   = m_owner;
            frc = (m_hold == MH) && ((r & ~(4'b0001 << k)) != 0);
            if (d || !r[k] || frc) begin
                m_ptr = (k + 1) % N;
                w = pick(r, m_ptr);
                if (w >= 0) begin
                    m_owner = w; m_last = w; m_hold = 1;
                    m_pre   = frc && !d && r[k];
                end else begin
                    m_owner = -1;
                end
            end else if (m_hold < MH) begin
                m_hold++;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] r, input logic d);
        req = r; done = d;
        @(posedge clk);
        model_update(r, d);
        @(negedge clk);
    endtask

    task automatic invariants(input string tag);
        check({tag, " onehot"}, int'($onehot0(gnt)), 1);
        check({tag, " valid"}, int'(valid), int'(|gnt));
        check({tag, " gnt_at_id"}, int'(gnt[gid]), int'(valid));
    endtask

    initial begin
        model_reset();
        req = 4'b1111;
        repeat (2) @(negedge clk);
        check("reset gnt", int'(gnt), 0);
        check("reset valid", int'(valid), 0);
        check("reset id", int'(gid), 0);
        check("reset pre", int'(pre), 0);
        rst = 1'b0;

        // reset release and rotation
        add(4'b1111, 0, 4'b0001, 0, 0); add(4'b1111, 0, 4'b0001, 0, 0);
        add(4'b1111, 0, 4'b0001, 0, 0); add(4'b1111, 1, 4'b0010, 1, 0);
        add(4'b1111, 0, 4'b0010, 1, 0); add(4'b1111, 0, 4'b0010, 1, 0);
        add(4'b1111, 1, 4'b0100, 2, 0); add(4'b1111, 0, 4'b0100, 2, 0);
        add(4'b1111, 0, 4'b0100, 2, 0); add(4'b1111, 1, 4'b1000, 3, 0);
        add(4'b1111, 0, 4'b1000, 3, 0); add(4'b1111, 0, 4'b1000, 3, 0);
        add(4'b1111, 1, 4'b0001, 0, 0); add(4'b0000, 0, 4'b0000, 0, 0);
        // forced release after MAX_HOLD cycles
        add(4'b0001, 0, 4'b0001, 0, 0); add(4'b0001, 0, 4'b0001, 0, 0);
        add(4'b0101, 0, 4'b0001, 0, 0); add(4'b0101, 0, 4'b0001, 0, 0);
        add(4'b0101, 0, 4'b0100, 2, 1); add(4'b0101, 0, 4'b0100, 2, 0);
        // re-grant to same owner, abort, idle, done while idle
        add(4'b0100, 1, 4'b0100, 2, 0); add(4'b0010, 0, 4'b0010, 1, 0);
        add(4'b0000, 0, 4'b0000, 1, 0); add(4'b0000, 1, 4'b0000, 1, 0);
        add(4'b0010, 0, 4'b0010, 1, 0);
        // done coincident with forced release, then hold saturation
        add(4'b1010, 0, 4'b0010, 1, 0); add(4'b1010, 0, 4'b0010, 1, 0);
        add(4'b1010, 0, 4'b0010, 1, 0); add(4'b1010, 1, 4'b1000, 3, 0);
        add(4'b1000, 0, 4'b1000, 3, 0); add(4'b1000, 0, 4'b1000, 3, 0);
        add(4'b1000, 0, 4'b1000, 3, 0); add(4'b1000, 0, 4'b1000, 3, 0);
        add(4'b1000, 0, 4'b1000, 3, 0); add(4'b1001, 0, 4'b0001, 0, 1);
        add(4'b0000, 0, 4'b0000, 0, 0);

        foreach (tbl[i]) begin
            step(tbl[i].req, tbl[i].done);
            check($sformatf("vec%0d gnt", i), int'(gnt), int'(tbl[i].gnt));
            check($sformatf("vec%0d id", i), int'(gid), tbl[i].id);
            check($sformatf("vec%0d pre", i), int'(pre), int'(tbl[i].pre));
            invariants($sformatf("vec%0d", i));
        end

        // async reset mid-grant
        step(4'b1000, 0);
        check("pre_rst gnt", int'(gnt), 4'b1000);
        #1 rst = 1'b1;
        #1;
        check("async gnt", int'(gnt), 0);
        check("async valid", int'(valid), 0);
        check("async id", int'(gid), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        step(4'b1010, 0);
        check("post_rst gnt", int'(gnt), 4'b0010);
        check("post_rst id", int'(gid), 1);

        // randomized run against the model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        req  = '0;
        maxw = 0;
        for (int c = 0; c < 3000; c++) begin
            logic [N-1:0] r;
            logic         d;
            r = req;
            for (int b = 0; b < N; b++) begin
                if (r[b]) begin
                    if ($urandom_range(0, 15) == 0) r[b] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    r[b] = 1'b1;
                end
            end
            d = ($urandom_range(0, 4) == 0);
            step(r, d);
            check("rnd gnt", int'(gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
            check("rnd id", int'(gid), m_last);
            check("rnd valid", int'(valid), int'(m_owner >= 0));
            check("rnd pre", int'(pre), int'(m_pre));
            invariants("rnd");
            for (int b = 0; b < N; b++) begin
                if (r[b] && m_owner != b) wt[b]++;
                else wt[b] = 0;
                if (wt[b] > maxw) maxw = wt[b];
            end
        end
        check("starvation bound", int'(maxw <= BOUND), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
